// File: rtl/uart_rx_deserializer.sv
// UART receive datapath: synchronizes the serial line, finds the start bit,
// samples each bit at its middle using the oversample strobe, assembles the
// character LSB first, checks the stop bit and hands the result to a
// one-entry holding register with a valid/ready consumer interface.
//
// Handshake: data_valid is high while the holding register is full; a
// transfer happens on every clk_in edge where data_valid & data_ready are
// both 1. data_out holds steady while data_valid is high, except when a
// transfer and a new delivery land on the same edge.
module uart_rx_deserializer #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk_in,
   input  logic                 resetN,
   input  logic                 rx_tick,
   input  logic                 rx_en,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 framing_error,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   state_t                 state_q, state_d;
   logic [TW-1:0]          tick_q, tick_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic                   deliver;
   logic                   frame_err;

   // Line synchronizer; flops reset to the idle (high) level so reset never looks like a start bit.
   always_ff @(posedge clk_in) begin
      if (!resetN) sync_q <= '1;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   // Frame FSM registers: state, oversample counter, data bit counter, shift register.
   always_ff @(posedge clk_in) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Next-state logic; counters only move on rx_tick, rx_en=0 aborts to IDLE.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      deliver   = 1'b0;
      frame_err = 1'b0;
      if (!rx_en) begin
         state_d = ST_IDLE;
         tick_d  = '0;
         bit_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rx_tick && !rxs) begin
                  state_d = ST_START;
                  tick_d  = '0;
               end
            end
            ST_START: begin
               if (rx_tick) begin
                  if (tick_q == HALF_LAST) begin
                     // High at mid start bit means a glitch: quietly go back to idle.
                     tick_d  = '0;
                     bit_d   = '0;
                     state_d = rxs ? ST_IDLE : ST_DATA;
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (rx_tick) begin
                  if (tick_q == FULL_LAST) begin
                     shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                     tick_d  = '0;
                     bit_d   = bit_q + 1'b1;
                     if (bit_q == LAST_BIT) state_d = ST_STOP;
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (rx_tick) begin
                  if (tick_q == FULL_LAST) begin
                     tick_d = '0;
                     bit_d  = '0;
                     if (rxs) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                     end else begin
                        frame_err = 1'b1;
                        state_d   = ST_WAIT_HIGH;
                     end
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               // A held-low line (break) must return high before a new start can be seen.
               if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Holding register, handshake and status pulses.
   always_ff @(posedge clk_in) begin
      if (!resetN) begin
         data_out      <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= frame_err;
         overrun       <= deliver & data_valid & ~data_ready;
         if (deliver && (!data_valid || data_ready)) begin
            data_out   <= shift_q;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: drives whole UART frames on rxd, predicts
// delivered bytes and error pulses from frame-level rules, and checks the DUT
// output stream and handshake behaviour from an independent monitor.
module tb_uart_rx_deserializer;

   localparam int DB = 8;
   localparam int OS = 16;
   localparam int TP = 4;

   logic          clk_in = 1'b0;
   logic          resetN = 1'b0;
   logic          rx_tick = 1'b0;
   logic          rx_en = 1'b1;
   logic          rxd = 1'b1;
   logic          data_ready = 1'b1;
   logic [DB-1:0] data_out;
   logic          data_valid;
   logic          framing_error;
   logic          overrun;
   logic          busy;

   int            checks = 0;
   int            errors = 0;
   logic [DB-1:0] exp_q[$];
   int            exp_ferr = 0;
   int            exp_ovr = 0;
   int            seen_ferr = 0;
   int            seen_ovr = 0;
   bit            model_full = 1'b0;
   bit            mon_on = 1'b0;

   uart_rx_deserializer #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .clk_in        (clk_in),
      .resetN        (resetN),
      .rx_tick       (rx_tick),
      .rx_en         (rx_en),
      .rxd           (rxd),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .framing_error (framing_error),
      .overrun       (overrun),
      .busy          (busy)
   );

   // clock / reset / strobe
   always #5 clk_in = ~clk_in;

   initial begin
      forever begin
         repeat (TP - 1) @(posedge clk_in);
         #1 rx_tick = 1'b1;
         @(posedge clk_in);
         #1 rx_tick = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // driver tasks
   task automatic wait_ticks(input int n);
      int k = 0;
      while (k < n) begin
         @(posedge clk_in);
         if (rx_tick) k++;
      end
      #1;
   endtask

   // Frame starts right after a tick edge; optional 1-cycle ready pulse lands on the stop-sample edge.
   task automatic send_frame(input logic [DB-1:0] d, input bit stop_val, input bit pulse_ready);
      fork
         begin
            rxd = 1'b0;
            wait_ticks(OS);
            for (int i = 0; i < DB; i++) begin
               rxd = d[i];
               wait_ticks(OS);
            end
            rxd = stop_val;
            wait_ticks(OS);
         end
         begin
            if (pulse_ready) begin
               wait_ticks(OS * (DB + 1) + OS / 2);
               repeat (TP - 1) @(posedge clk_in);
               #1 data_ready = 1'b1;
               @(posedge clk_in);
               #1 data_ready = 1'b0;
            end
         end
      join
   endtask

   // Reference model: mode 0 consumer stalled, 1 always ready, 2 ready only at delivery.
   task automatic model_frame(input logic [DB-1:0] d, input bit stop_ok, input int mode);
      if (!stop_ok) exp_ferr++;
      else if (mode == 0 && model_full) exp_ovr++;
      else begin
         exp_q.push_back(d);
         model_full = (mode != 1);
      end
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_ferr_count"}, seen_ferr, exp_ferr);
      check({tag, "_ovr_count"}, seen_ovr, exp_ovr);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      data_ready = 1'b1;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk_in);
         n++;
      end
      #1;
      check({tag, "_drain"}, exp_q.size(), 0);
      model_full = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data_out"}, data_out, 0);
      check({tag, "_valid"}, data_valid, 0);
      check({tag, "_ferr"}, framing_error, 0);
      check({tag, "_ovr"}, overrun, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // scoreboard monitor
   logic          prev_valid = 1'b0;
   logic          prev_ready = 1'b0;
   logic          prev_tick = 1'b0;
   logic          prev_accept = 1'b0;
   logic          prev_ferr = 1'b0;
   logic          prev_ovr = 1'b0;
   logic [DB-1:0] prev_data = '0;

   always @(negedge clk_in) begin
      if (mon_on) begin
         if (data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL accept_unexpected: got %0h, expected no byte (t=%0t)", data_out, $time);
            end else begin
               check("accept_data", data_out, exp_q.pop_front());
            end
         end
         if (data_valid && !prev_valid) check("valid_latency_tick", prev_tick, 1);
         if (prev_accept && !prev_tick) check("valid_drop", data_valid, 0);
         if (data_valid && prev_valid && !prev_ready) check("data_hold", data_out, prev_data);
         if (framing_error) begin
            seen_ferr++;
            check("ferr_width", prev_ferr, 0);
            check("ferr_ovr_excl", overrun, 0);
         end
         if (overrun) begin
            seen_ovr++;
            check("ovr_width", prev_ovr, 0);
         end
      end
      prev_accept = data_valid & data_ready;
      prev_valid  = data_valid;
      prev_ready  = data_ready;
      prev_tick   = rx_tick;
      prev_ferr   = framing_error;
      prev_ovr    = overrun;
      prev_data   = data_out;
   end

   // watchdog
   initial begin
      #1_500_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      logic [DB-1:0] d;
      bit            ok;

      // reset
      repeat (3) @(posedge clk_in);
      #1;
      check_reset_outputs("reset");
      resetN = 1'b1;
      mon_on = 1'b1;
      repeat (4) @(posedge clk_in);

      // 0x55 with a consumer that is always ready
      data_ready = 1'b1;
      model_frame(8'h55, 1'b1, 1);
      wait_ticks(1);
      send_frame(8'h55, 1'b1, 1'b0);
      wait_ticks(4);
      check_counts("t1");
      check("t1_busy", busy, 0);

      // short low glitch from idle
      rxd = 1'b0;
      wait_ticks(3);
      rxd = 1'b1;
      wait_ticks(20);
      check("t2_busy", busy, 0);
      check("t2_valid", data_valid, 0);
      check_counts("t2");

      // bad stop bit, line held low, then a good frame
      model_frame(8'hA3, 1'b0, 1);
      wait_ticks(1);
      send_frame(8'hA3, 1'b0, 1'b0);
      wait_ticks(40);
      check("t3_busy_held", busy, 1);
      check("t3_valid", data_valid, 0);
      check_counts("t3a");
      rxd = 1'b1;
      wait_ticks(2);
      check("t3_busy_release", busy, 0);
      model_frame(8'h3C, 1'b1, 1);
      send_frame(8'h3C, 1'b1, 1'b0);
      wait_ticks(4);
      check_counts("t3b");

      // overrun with a stalled consumer
      data_ready = 1'b0;
      model_frame(8'h11, 1'b1, 0);
      wait_ticks(1);
      send_frame(8'h11, 1'b1, 1'b0);
      model_frame(8'h22, 1'b1, 0);
      send_frame(8'h22, 1'b1, 1'b0);
      wait_ticks(2);
      check("t4_held_byte", data_out, 8'h11);
      check("t4_held_valid", data_valid, 1);
      check_counts("t4a");
      drain("t4a");

      // accept and delivery on the same edge: no overrun
      data_ready = 1'b0;
      model_frame(8'h11, 1'b1, 0);
      wait_ticks(1);
      send_frame(8'h11, 1'b1, 1'b0);
      model_frame(8'h22, 1'b1, 2);
      send_frame(8'h22, 1'b1, 1'b1);
      wait_ticks(2);
      check("t4_replaced_byte", data_out, 8'h22);
      check("t4_replaced_valid", data_valid, 1);
      check_counts("t4b");
      drain("t4b");

      // reset in the middle of a frame
      data_ready = 1'b1;
      wait_ticks(1);
      fork
         send_frame(8'hFF, 1'b1, 1'b0);
         begin
            wait_ticks(OS * 5 + OS / 2);
            check("t5_busy_before", busy, 1);
            resetN = 1'b0;
            @(posedge clk_in);
            #1 resetN = 1'b1;
            check_reset_outputs("t5_reset");
         end
      join
      wait_ticks(2);
      model_frame(8'h81, 1'b1, 1);
      send_frame(8'h81, 1'b1, 1'b0);
      wait_ticks(4);
      check_counts("t5");

      // rx_en dropped mid-frame
      wait_ticks(1);
      fork
         send_frame(8'h7E, 1'b1, 1'b0);
         begin
            wait_ticks(OS * 3 + 4);
            check("t6_busy_before", busy, 1);
            rx_en = 1'b0;
            @(posedge clk_in);
            #1;
            check("t6_busy_after", busy, 0);
         end
      join
      wait_ticks(2);
      check("t6_valid", data_valid, 0);
      check_counts("t6a");
      rx_en = 1'b1;
      model_frame(8'h7E, 1'b1, 1);
      wait_ticks(1);
      send_frame(8'h7E, 1'b1, 1'b0);
      wait_ticks(4);
      check_counts("t6b");

      // random frames, occasional bad stop bit
      for (int n = 0; n < 10; n++) begin
         d  = DB'($urandom_range(0, 255));
         ok = ($urandom_range(0, 3) != 0);
         model_frame(d, ok, 1);
         wait_ticks(1);
         send_frame(d, ok, 1'b0);
         if (!ok) begin
            wait_ticks($urandom_range(2, 30));
            rxd = 1'b1;
         end
         wait_ticks($urandom_range(2, 12));
         check("rnd_busy_idle", busy, 0);
      end

      drain("final");
      check_counts("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
